// File: rtl/calc_pkg.sv
// Shared encodings, ASCII constants and FSM states for the UART calculator command parser.
package calc_pkg;

    localparam logic [3:0] DTYPE_I = 4'b0001;
    localparam logic [3:0] DTYPE_U = 4'b0010;
    localparam logic [3:0] DTYPE_S = 4'b0100;
    localparam logic [3:0] DTYPE_H = 4'b1000;

    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_MUL = 5'b00100;
    localparam logic [4:0] OP_DIV = 5'b01000;
    localparam logic [4:0] OP_MOD = 5'b10000;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_UA    = 8'h41;
    localparam logic [7:0] CH_UF    = 8'h46;
    localparam logic [7:0] CH_LA    = 8'h61;
    localparam logic [7:0] CH_LF    = 8'h66;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_PCT   = 8'h25;
    localparam logic [7:0] CH_I     = 8'h49;
    localparam logic [7:0] CH_U     = 8'h55;
    localparam logic [7:0] CH_S     = 8'h53;
    localparam logic [7:0] CH_H     = 8'h48;

    typedef enum logic [2:0] {
        IDLE,
        TSEP,
        SRC1,
        SRC2,
        DONE,
        ERR
    } state_e;

    // Zero means "not an operator character".
    function automatic logic [4:0] op_decode(input logic [7:0] ch);
        case (ch)
            CH_PLUS:  return OP_ADD;
            CH_MINUS: return OP_SUB;
            CH_STAR:  return OP_MUL;
            CH_SLASH: return OP_DIV;
            CH_PCT:   return OP_MOD;
            default:  return 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/calc_digit_acc.sv
// Operand accumulator: classifies an ASCII digit in the current radix and folds it into acc,
// flagging any result that would not fit in OPERAND_W bits.
module calc_digit_acc
    import calc_pkg::*;
#(
    parameter int OPERAND_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic                 hex_i,
    input  logic [7:0]           char_i,
    output logic                 is_digit_o,
    output logic                 ovf_o,
    output logic [OPERAND_W-1:0] acc_o
);

    logic [OPERAND_W-1:0] acc_q, acc_d;
    logic [3:0]           nibble;
    logic [OPERAND_W+4:0] product;
    logic [OPERAND_W+4:0] sum;

    always_comb begin
        is_digit_o = 1'b0;
        nibble     = 4'd0;
        if (char_i >= CH_0 && char_i <= CH_9) begin
            is_digit_o = 1'b1;
            nibble     = char_i[3:0];
        end else if (hex_i && ((char_i >= CH_UA && char_i <= CH_UF) ||
                               (char_i >= CH_LA && char_i <= CH_LF))) begin
            // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15.
            is_digit_o = 1'b1;
            nibble     = char_i[3:0] + 4'd9;
        end
    end

    always_comb begin
        if (hex_i) begin
            product = {5'b00000, acc_q} << 4;
        end else begin
            product = ({5'b00000, acc_q} << 3) + ({5'b00000, acc_q} << 1);
        end
        sum   = product + {{(OPERAND_W+1){1'b0}}, nibble};
        ovf_o = |sum[OPERAND_W+4:OPERAND_W];
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (load_i) begin
            acc_d = sum[OPERAND_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/calc_cmd_parser.sv
// ASCII "<T> <src1><op><src2>=" command decoder feeding the ALU stage.
// Define CALC_PARSER_HEX_EN to accept type 'H' with base-16 operands.
module calc_cmd_parser
    import calc_pkg::*;
#(
    parameter int         OPERAND_W = 16,
    parameter logic [7:0] TERM_CHAR = 8'h3D
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [3:0]           dtype,
    output logic [4:0]           operator,
    output logic [OPERAND_W-1:0] src1,
    output logic [OPERAND_W-1:0] src2,
    output logic                 parser_done,
    output logic                 parser_err
);

    state_e               state_q, state_d;
    logic [3:0]           type_q, type_d;
    logic                 hex_q, hex_d;
    logic [4:0]           op_q, op_d;
    logic [OPERAND_W-1:0] hold_q, hold_d;
    logic                 seen_q, seen_d;
    logic [3:0]           dtype_q, dtype_d;
    logic [4:0]           operator_q, operator_d;
    logic [OPERAND_W-1:0] src1_q, src1_d;
    logic [OPERAND_W-1:0] src2_q, src2_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 acc_clear, acc_load, is_digit, ovf;
    logic [OPERAND_W-1:0] acc;
    logic [4:0]           op_code;
    logic                 is_term;

    calc_digit_acc #(.OPERAND_W(OPERAND_W)) u_acc (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (acc_clear),
        .load_i    (acc_load),
        .hex_i     (hex_q),
        .char_i    (rx_data),
        .is_digit_o(is_digit),
        .ovf_o     (ovf),
        .acc_o     (acc)
    );

    assign op_code = op_decode(rx_data);
    assign is_term = (rx_data == TERM_CHAR);

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        hex_d      = hex_q;
        op_d       = op_q;
        hold_d     = hold_q;
        seen_d     = seen_q;
        dtype_d    = dtype_q;
        operator_d = operator_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        acc_clear  = 1'b0;
        acc_load   = 1'b0;

        if (state_q == DONE) begin
            state_d = IDLE;
        end

        if (rx_valid) begin
            case (state_q)
                // DONE lasts one cycle, so a back-to-back type char is taken as in IDLE.
                IDLE, DONE: begin
                    acc_clear = 1'b1;
                    state_d   = TSEP;
                    hex_d     = 1'b0;
                    if (rx_data == CH_I) begin
                        type_d = DTYPE_I;
                    end else if (rx_data == CH_U) begin
                        type_d = DTYPE_U;
                    end else if (rx_data == CH_S) begin
                        type_d = DTYPE_S;
`ifdef CALC_PARSER_HEX_EN
                    end else if (rx_data == CH_H) begin
                        type_d = DTYPE_H;
                        hex_d  = 1'b1;
`endif
                    end else begin
                        err_d   = 1'b1;
                        state_d = is_term ? IDLE : ERR;
                    end
                end
                TSEP: begin
                    if (rx_data == CH_SPACE) begin
                        state_d = SRC1;
                        seen_d  = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = is_term ? IDLE : ERR;
                    end
                end
                SRC1, SRC2: begin
                    if (rx_data == CH_SPACE) begin
                        state_d = state_q;
                    end else if (is_digit && !ovf) begin
                        acc_load = 1'b1;
                        seen_d   = 1'b1;
                    end else if (state_q == SRC1 && op_code != 5'b00000 && seen_q) begin
                        state_d   = SRC2;
                        hold_d    = acc;
                        op_d      = op_code;
                        acc_clear = 1'b1;
                        seen_d    = 1'b0;
                    end else if (state_q == SRC2 && is_term && seen_q) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        dtype_d    = type_q;
                        operator_d = op_q;
                        src1_d     = hold_q;
                        src2_d     = acc;
                    end else begin
                        err_d   = 1'b1;
                        state_d = is_term ? IDLE : ERR;
                    end
                end
                ERR: begin
                    if (is_term) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            type_q     <= '0;
            hex_q      <= 1'b0;
            op_q       <= '0;
            hold_q     <= '0;
            seen_q     <= 1'b0;
            dtype_q    <= '0;
            operator_q <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            hex_q      <= hex_d;
            op_q       <= op_d;
            hold_q     <= hold_d;
            seen_q     <= seen_d;
            dtype_q    <= dtype_d;
            operator_q <= operator_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign dtype       = dtype_q;
    assign operator    = operator_q;
    assign src1        = src1_q;
    assign src2        = src2_q;
    assign parser_done = done_q;
    assign parser_err  = err_q;

endmodule

// File: tb/tb_calc_cmd_parser.sv
// Bench for calc_cmd_parser: directed and random commands against a whole-command reference parser.
// Honours CALC_PARSER_HEX_EN when the DUT is built with it.
module tb_calc_cmd_parser;

    localparam int W = 16;

    typedef logic [7:0] byteQ_t[$];

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rxData;
    logic         rxValid;
    logic [3:0]   dtype;
    logic [4:0]   operator;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic         parserDone;
    logic         parserErr;

    int checkCount = 0;
    int errorCount = 0;

    bit           pendErr, pendDone;
    logic [3:0]   expDt, stDt;
    logic [4:0]   expOp, stOp;
    logic [W-1:0] expS1, expS2, stS1, stS2;

    calc_cmd_parser #(.OPERAND_W(W), .TERM_CHAR(8'h3D)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rxData),
        .rx_valid   (rxValid),
        .dtype      (dtype),
        .operator   (operator),
        .src1       (src1),
        .src2       (src2),
        .parser_done(parserDone),
        .parser_err (parserErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Compare everything visible after the previous rising edge against the model.
    task automatic checkCycle();
        if (pendDone) begin
            expDt = stDt;
            expOp = stOp;
            expS1 = stS1;
            expS2 = stS2;
        end
        checkOutput("parser_err", 32'(parserErr), 32'(pendErr));
        checkOutput("parser_done", 32'(parserDone), 32'(pendDone));
        checkOutput("dtype", 32'(dtype), 32'(expDt));
        checkOutput("operator", 32'(operator), 32'(expOp));
        checkOutput("src1", 32'(src1), 32'(expS1));
        checkOutput("src2", 32'(src2), 32'(expS2));
    endtask

    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit e, input bit dn);
        @(negedge clk);
        checkCycle();
        rxValid  = v;
        rxData   = d;
        pendErr  = e;
        pendDone = dn;
    endtask

    task automatic applyReset();
        @(negedge clk);
        checkCycle();
        rst      = 1'b1;
        rxValid  = 1'b1;
        rxData   = 8'h35;
        pendErr  = 1'b0;
        pendDone = 1'b0;
        expDt    = '0;
        expOp    = '0;
        expS1    = '0;
        expS2    = '0;
        @(negedge clk);
        checkCycle();
        rst     = 1'b0;
        rxValid = 1'b0;
    endtask

    function automatic int digitVal(input logic [7:0] ch, input bit hex);
        if (ch >= 8'h30 && ch <= 8'h39) return int'(ch) - 48;
        if (hex && ch >= 8'h41 && ch <= 8'h46) return int'(ch) - 55;
        if (hex && ch >= 8'h61 && ch <= 8'h66) return int'(ch) - 87;
        return -1;
    endfunction

    function automatic logic [4:0] opCode(input logic [7:0] ch);
        case (ch)
            8'h2B:   return 5'b00001;
            8'h2D:   return 5'b00010;
            8'h2A:   return 5'b00100;
            8'h2F:   return 5'b01000;
            8'h25:   return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    // Parses one complete command (exactly one '=' at its end); errIdx=-1 means a good command.
    function automatic void refParse(input byteQ_t c, output int errIdx, output logic [3:0] dt,
                                     output logic [4:0] op, output logic [W-1:0] s1, output logic [W-1:0] s2);
        longint radix;
        longint maxv;
        longint val;
        longint vals[2];
        int     i;
        int     n;
        int     d;
        errIdx = -1;
        dt     = '0;
        op     = '0;
        s1     = '0;
        s2     = '0;
        radix  = 10;
        maxv   = (longint'(1) << W) - 1;
        case (c[0])
            8'h49: dt = 4'b0001;
            8'h55: dt = 4'b0010;
            8'h53: dt = 4'b0100;
`ifdef CALC_PARSER_HEX_EN
            8'h48: begin dt = 4'b1000; radix = 16; end
`endif
            default: begin errIdx = 0; return; end
        endcase
        if (c[1] != 8'h20) begin errIdx = 1; return; end
        i = 2;
        for (int k = 0; k < 2; k++) begin
            val = 0;
            n   = 0;
            while (i < c.size()) begin
                d = digitVal(c[i], radix == 16);
                if (c[i] == 8'h20) begin
                    i++;
                end else if (d >= 0) begin
                    val = val * radix + longint'(d);
                    if (val > maxv) begin errIdx = i; return; end
                    n++;
                    i++;
                end else begin
                    break;
                end
            end
            vals[k] = val;
            if (k == 0) begin
                op = opCode(c[i]);
                if (op == 5'b00000 || n == 0) begin errIdx = i; return; end
            end else if (c[i] != 8'h3D || n == 0) begin
                errIdx = i;
                return;
            end
            i++;
        end
        s1 = vals[0][W-1:0];
        s2 = vals[1][W-1:0];
    endfunction

    function automatic byteQ_t toQ(input string s);
        byteQ_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // gapMode < 0 picks a random 0..2 idle cycles after each byte.
    task automatic sendCmd(input byteQ_t c, input int gapMode);
        int         errIdx;
        int         g;
        bit         dn;
        logic [3:0] dt;
        logic [4:0] op;
        logic [W-1:0] s1, s2;
        refParse(c, errIdx, dt, op, s1, s2);
        for (int i = 0; i < c.size(); i++) begin
            dn = (errIdx < 0) && (i == c.size() - 1);
            if (dn) begin
                stDt = dt;
                stOp = op;
                stS1 = s1;
                stS2 = s2;
            end
            applyStimulus(1'b1, c[i], i == errIdx, dn);
            g = (gapMode < 0) ? int'($urandom_range(0, 2)) : gapMode;
            repeat (g) applyStimulus(1'b0, 8'($urandom), 1'b0, 1'b0);
        end
    endtask

    task automatic sendPartial(input string s, input int gapMode);
        for (int i = 0; i < s.len(); i++) begin
            applyStimulus(1'b1, s[i], 1'b0, 1'b0);
            repeat (gapMode) applyStimulus(1'b0, 8'($urandom), 1'b0, 1'b0);
        end
    endtask

    function automatic byteQ_t genCmd();
        byteQ_t c;
        string  types  = "IUSHX";
        string  junk   = "aGx-+.Z ";
        string  ops    = "+-*/%";
        string  hexDig = "0123456789abcdefABCDEF";
        logic [7:0] t;
        bit     hexish;
        int     nd;
        t      = types[$urandom_range(0, 4)];
        hexish = (t == 8'h48) || ($urandom_range(0, 9) == 0);
        c.push_back(t);
        c.push_back(($urandom_range(0, 19) == 0) ? junk[$urandom_range(0, 7)] : 8'h20);
        for (int k = 0; k < 2; k++) begin
            nd = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 5));
            for (int j = 0; j < nd; j++) begin
                if ($urandom_range(0, 9) == 0) c.push_back(8'h20);
                c.push_back(hexish ? hexDig[$urandom_range(0, 21)] : 8'(8'h30 + $urandom_range(0, 9)));
            end
            if (k == 0) begin
                c.push_back(($urandom_range(0, 19) == 0) ? junk[$urandom_range(0, 7)] : ops[$urandom_range(0, 4)]);
            end
        end
        c.push_back(8'h3D);
        return c;
    endfunction

    initial begin
        string directed[10];
        int    gaps[2];
        directed = '{"I 1234-5678=", "U 65535+1=", "U 65536+1=", "S 7*8=", "I 12a3+4=",
                     "I 9%2=", "I +5=", "I 5=", "U 1/1=", "H fF%A="};
        gaps     = '{0, 2};
        rst      = 1'b1;
        rxValid  = 1'b0;
        rxData   = 8'h00;
        pendErr  = 1'b0;
        pendDone = 1'b0;
        expDt = '0; expOp = '0; expS1 = '0; expS2 = '0;
        stDt  = '0; stOp  = '0; stS1  = '0; stS2  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkCycle();
        rst = 1'b0;

        foreach (gaps[g]) begin
            foreach (directed[i]) sendCmd(toQ(directed[i]), gaps[g]);
            sendPartial("I 12", gaps[g]);
            applyReset();
            sendCmd(toQ("S 3/4="), gaps[g]);
        end

        for (int n = 0; n < 400; n++) begin
            sendCmd(genCmd(), -1);
            if ($urandom_range(0, 49) == 0) begin
                sendPartial("U 7", 0);
                applyReset();
            end
        end

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
